// File: rtl/crane_pkg.sv
// ============================================================================
//  Module      : crane_pkg
//  Description : Shared crane action codes, arbiter state encoding, helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package crane_pkg;

    localparam int N_REQ = 4;

    // Action codes reported by the crane FSM
    localparam logic [2:0] c_act_dn      = 3'b000;
    localparam logic [2:0] c_act_a1      = 3'b001;
    localparam logic [2:0] c_act_up      = 3'b010;
    localparam logic [2:0] c_act_a2      = 3'b011;
    localparam logic [2:0] c_act_r1      = 3'b100;
    localparam logic [2:0] c_act_r2      = 3'b101;
    localparam logic [2:0] c_act_nothing = 3'b110;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ISSUE      = 3'd1,
        ST_WAIT_START = 3'd2,
        ST_RUN        = 3'd3,
        ST_RETURN     = 3'd4,
        ST_FAULT      = 3'd5
    } arb_state_t;

    function automatic logic [1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < N_REQ; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/crane_job_arbiter_if.sv
// ============================================================================
//  Module      : crane_job_arbiter_if
//  Description : Station request / crane handshake bundle for the job arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface crane_job_arbiter_if;
    import crane_pkg::*;

    logic [N_REQ-1:0]   req;
    logic [2*N_REQ-1:0] req_angle;
    logic [2:0]         crane_action;
    logic               fault_clr;
    logic [N_REQ-1:0]   ack;
    logic [N_REQ-1:0]   done;
    logic               crane_write_mode;
    logic [1:0]         crane_mode_in;
    logic               busy;
    logic               fault;

    modport master (
        output req, req_angle, crane_action, fault_clr,
        input  ack, done, crane_write_mode, crane_mode_in, busy, fault
    );

    modport slave (
        input  req, req_angle, crane_action, fault_clr,
        output ack, done, crane_write_mode, crane_mode_in, busy, fault
    );

endinterface

`default_nettype wire

// File: rtl/crane_rr_pick.sv
// ============================================================================
//  Module      : crane_rr_pick
//  Description : Combinational 4-way pick starting at a pointer, with wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module crane_rr_pick
    import crane_pkg::*;
(
    input  wire logic [N_REQ-1:0] i_req,
    input  wire logic [1:0]       i_ptr,
    output logic      [N_REQ-1:0] o_grant,
    output logic                  o_valid
);

    // Walk from the farthest offset down so the nearest requester wins last
    always_comb begin
        o_grant = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (i_req[i_ptr + 2'(k)]) begin
                o_grant = N_REQ'(1) << (i_ptr + 2'(k));
            end
        end
    end

    assign o_valid = |i_req;

endmodule

`default_nettype wire

// File: rtl/crane_job_arbiter.sv
// ============================================================================
//  Module      : crane_job_arbiter
//  Description : Grants one station at a time to the crane and tracks the job
//                to completion with a stall watchdog. Define
//                CRANE_ARB_FIXED_PRIO_EN for fixed priority (req[0] highest).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module crane_job_arbiter
    import crane_pkg::*;
#(
    parameter logic [7:0] TIMEOUT = 8'd200
) (
    input wire logic          clk,
    input wire logic          reset_n,
    crane_job_arbiter_if.slave bus
);

    arb_state_t       r_state;
    logic [1:0]       r_ptr;
    logic [1:0]       r_winner;
    logic [7:0]       r_cnt;
    logic [N_REQ-1:0] r_ack;
    logic [N_REQ-1:0] r_done;
    logic             r_write_mode;
    logic [1:0]       r_mode_in;
    logic             r_busy;
    logic             r_fault;

    logic [N_REQ-1:0] w_grant;
    logic             w_valid;
    logic [1:0]       w_winner;
    logic [1:0]       w_angle;
    logic [1:0]       w_ptr_next;
    logic             w_timeout;

    crane_rr_pick u_pick (
        .i_req   (bus.req),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_valid (w_valid)
    );

    assign w_winner  = onehot_to_idx(w_grant);
    assign w_angle   = bus.req_angle[{w_winner, 1'b0} +: 2];
    assign w_timeout = (r_cnt == TIMEOUT - 8'd1);

`ifdef CRANE_ARB_FIXED_PRIO_EN
    assign w_ptr_next = 2'd0;
`else
    assign w_ptr_next = r_winner + 2'd1;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_ptr        <= 2'd0;
            r_winner     <= 2'd0;
            r_cnt        <= 8'd0;
            r_ack        <= '0;
            r_done       <= '0;
            r_write_mode <= 1'b0;
            r_mode_in    <= 2'd0;
            r_busy       <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_ack        <= '0;
            r_done       <= '0;
            r_write_mode <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_winner     <= w_winner;
                        r_ack        <= w_grant;
                        r_write_mode <= 1'b1;
                        r_mode_in    <= w_angle;
                        r_busy       <= 1'b1;
                        r_state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_cnt   <= 8'd0;
                    r_state <= ST_WAIT_START;
                end
                // A matching action beats a coincident watchdog expiry
                ST_WAIT_START, ST_RUN, ST_RETURN: begin
                    if (r_state == ST_WAIT_START && bus.crane_action == c_act_dn) begin
                        r_cnt   <= 8'd0;
                        r_state <= ST_RUN;
                    end else if (r_state == ST_RUN && bus.crane_action == c_act_r2) begin
                        r_cnt   <= 8'd0;
                        r_state <= ST_RETURN;
                    end else if (r_state == ST_RETURN && bus.crane_action == c_act_nothing) begin
                        r_cnt   <= 8'd0;
                        r_done  <= N_REQ'(1) << r_winner;
                        r_ptr   <= w_ptr_next;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (w_timeout) begin
                        r_cnt   <= 8'd0;
                        r_fault <= 1'b1;
                        r_state <= ST_FAULT;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_FAULT: begin
                    if (bus.fault_clr) begin
                        r_fault <= 1'b0;
                        r_ptr   <= w_ptr_next;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ack              = r_ack;
    assign bus.done             = r_done;
    assign bus.crane_write_mode = r_write_mode;
    assign bus.crane_mode_in    = r_mode_in;
    assign bus.busy             = r_busy;
    assign bus.fault            = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_crane_job_arbiter.sv
// ============================================================================
//  Module      : tb_crane_job_arbiter
//  Description : Self-checking bench for crane_job_arbiter with a crane model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_crane_job_arbiter;

    localparam logic [7:0] c_timeout = 8'd16;
    localparam logic [2:0] c_dn      = 3'b000;
    localparam logic [2:0] c_up      = 3'b010;
    localparam logic [2:0] c_r2      = 3'b101;
    localparam logic [2:0] c_nothing = 3'b110;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   tests   = 0;
    int   fails   = 0;
    int   m_ptr   = 0;

    crane_job_arbiter_if bus ();

    crane_job_arbiter #(.TIMEOUT(c_timeout)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // Reference: first requester found scanning upward from the pointer
    function automatic int model_pick(input logic [3:0] r, input int ptr);
        int p;
        p = ptr;
`ifdef CRANE_ARB_FIXED_PRIO_EN
        p = 0;
`endif
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    function automatic int model_next_ptr(input int w);
`ifdef CRANE_ARB_FIXED_PRIO_EN
        return 0;
`else
        return (w + 1) % 4;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Full job: request, crane sequence, completion; returns observed ack
    task automatic do_job(input logic [3:0] rv, input logic [7:0] ang,
                          input int ds, input int dr, input int dt,
                          output logic [3:0] got_ack);
        int         w;
        logic [3:0] exp_oh;
        logic [1:0] exp_ang;
        w       = model_pick(rv, m_ptr);
        exp_oh  = 4'b0001 << w;
        exp_ang = ang[2*w +: 2];
        bus.req          = rv;
        bus.req_angle    = ang;
        bus.crane_action = c_nothing;
        tick();
        got_ack = bus.ack;
        tests++;
        if (bus.ack !== exp_oh || bus.crane_write_mode !== 1'b1 || bus.crane_mode_in !== exp_ang ||
            bus.busy !== 1'b1 || bus.done !== 4'b0) begin
            fails++;
            $display("FAIL grant: ack=%b wm=%b mode=%0d busy=%b done=%b, want ack=%b wm=1 mode=%0d busy=1 done=0000",
                     bus.ack, bus.crane_write_mode, bus.crane_mode_in, bus.busy, bus.done, exp_oh, exp_ang);
        end
        bus.req[w] = 1'b0;
        tick();
        tests++;
        if (bus.ack !== 4'b0 || bus.crane_write_mode !== 1'b0 || bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL issue: ack=%b wm=%b busy=%b, want ack=0000 wm=0 busy=1",
                     bus.ack, bus.crane_write_mode, bus.busy);
        end
        repeat (ds) tick();
        bus.crane_action = c_dn;
        tick();
        bus.crane_action = c_up;
        repeat (dr) tick();
        bus.crane_action = c_r2;
        tick();
        repeat (dt) tick();
        tests++;
        if (bus.crane_mode_in !== exp_ang || bus.done !== 4'b0 || bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL job_hold: mode=%0d done=%b busy=%b, want mode=%0d done=0000 busy=1",
                     bus.crane_mode_in, bus.done, bus.busy, exp_ang);
        end
        bus.crane_action = c_nothing;
        tick();
        tests++;
        if (bus.done !== exp_oh || bus.busy !== 1'b0 || bus.crane_mode_in !== exp_ang ||
            bus.crane_write_mode !== 1'b0) begin
            fails++;
            $display("FAIL done: done=%b busy=%b mode=%0d wm=%b, want done=%b busy=0 mode=%0d wm=0",
                     bus.done, bus.busy, bus.crane_mode_in, bus.crane_write_mode, exp_oh, exp_ang);
        end
        m_ptr   = model_next_ptr(w);
        bus.req = 4'b0;
    endtask

    task automatic test_reset();
        bus.req          = 4'b1111;
        bus.req_angle    = 8'hFF;
        bus.crane_action = c_nothing;
        bus.fault_clr    = 1'b0;
        reset_n          = 1'b0;
        tick();
        tick();
        tests++;
        if (bus.ack !== 4'b0) begin fails++; $display("FAIL reset_ack: got %b want 0000", bus.ack); end
        tests++;
        if (bus.done !== 4'b0) begin fails++; $display("FAIL reset_done: got %b want 0000", bus.done); end
        tests++;
        if (bus.crane_write_mode !== 1'b0) begin fails++; $display("FAIL reset_wm: got %b want 0", bus.crane_write_mode); end
        tests++;
        if (bus.crane_mode_in !== 2'd0) begin fails++; $display("FAIL reset_mode: got %0d want 0", bus.crane_mode_in); end
        tests++;
        if (bus.busy !== 1'b0 || bus.fault !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags: busy=%b fault=%b want 0 0", bus.busy, bus.fault);
        end
        bus.req = 4'b0;
        reset_n = 1'b1;
        m_ptr   = 0;
        tick();
        tests++;
        if (bus.busy !== 1'b0 || bus.ack !== 4'b0) begin
            fails++;
            $display("FAIL reset_idle: busy=%b ack=%b want 0 0000", bus.busy, bus.ack);
        end
    endtask

    task automatic test_single_job();
        logic [3:0] a;
        do_job(4'b0100, 8'b00_11_00_00, 2, 3, 2, a);
        tick();
        tests++;
        if (bus.done !== 4'b0 || bus.busy !== 1'b0 || bus.ack !== 4'b0) begin
            fails++;
            $display("FAIL single_after: done=%b busy=%b ack=%b want 0000 0 0000", bus.done, bus.busy, bus.ack);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] a;
        logic [3:0] exp_seq [4];
`ifdef CRANE_ARB_FIXED_PRIO_EN
        exp_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
        exp_seq = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
`endif
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        m_ptr   = 0;
        for (int i = 0; i < 4; i++) begin
            do_job(4'b1011, 8'($urandom), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                   int'($urandom_range(0, 4)), a);
            tests++;
            if (a !== exp_seq[i]) begin
                fails++;
                $display("FAIL rr_order[%0d]: ack=%b want %b", i, a, exp_seq[i]);
            end
        end
    endtask

    task automatic test_watchdog();
        int         w;
        logic       early;
        logic [3:0] a;
        w     = model_pick(4'b0100, m_ptr);
        early = 1'b0;
        bus.req          = 4'b0100;
        bus.crane_action = c_nothing;
        tick();
        tests++;
        if (bus.ack !== (4'b0001 << w)) begin
            fails++;
            $display("FAIL wd_grant: ack=%b want %b", bus.ack, 4'b0001 << w);
        end
        bus.req = 4'b0;
        tick();
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.fault !== 1'b0) early = 1'b1;
        end
        tests++;
        if (early !== 1'b0) begin fails++; $display("FAIL wd_early: fault rose before 16 cycles, want 0"); end
        bus.fault_clr = 1'b1;
        tick();
        tests++;
        if (bus.fault !== 1'b1 || bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL wd_raise: fault=%b busy=%b want 1 1", bus.fault, bus.busy);
        end
        bus.fault_clr = 1'b0;
        bus.req       = 4'b0001;
        repeat (3) tick();
        tests++;
        if (bus.fault !== 1'b1 || bus.ack !== 4'b0 || bus.crane_write_mode !== 1'b0) begin
            fails++;
            $display("FAIL wd_hold: fault=%b ack=%b wm=%b want 1 0000 0", bus.fault, bus.ack, bus.crane_write_mode);
        end
        bus.req       = 4'b0;
        bus.fault_clr = 1'b1;
        tick();
        bus.fault_clr = 1'b0;
        tests++;
        if (bus.fault !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 4'b0) begin
            fails++;
            $display("FAIL wd_clear: fault=%b busy=%b done=%b want 0 0 0000", bus.fault, bus.busy, bus.done);
        end
        m_ptr = model_next_ptr(w);
        do_job(4'b1111, 8'($urandom), 1, 1, 1, a);
    endtask

    task automatic test_mid_reset();
        logic [3:0] a;
        bus.req          = 4'b1000;
        bus.crane_action = c_nothing;
        tick();
        bus.req = 4'b0;
        tick();
        bus.crane_action = c_dn;
        tick();
        bus.crane_action = c_up;
        tick();
        tests++;
        if (bus.busy !== 1'b1) begin fails++; $display("FAIL mid_run_busy: got %b want 1", bus.busy); end
        reset_n = 1'b0;
        tick();
        tests++;
        if (bus.busy !== 1'b0 || bus.crane_write_mode !== 1'b0 || bus.ack !== 4'b0 || bus.done !== 4'b0) begin
            fails++;
            $display("FAIL mid_reset: busy=%b wm=%b ack=%b done=%b want 0 0 0000 0000",
                     bus.busy, bus.crane_write_mode, bus.ack, bus.done);
        end
        reset_n          = 1'b1;
        m_ptr            = 0;
        bus.crane_action = c_nothing;
        do_job(4'b0010, 8'b00_00_10_00, 1, 2, 1, a);
        tests++;
        if (a !== 4'b0010) begin fails++; $display("FAIL mid_regrant: ack=%b want 0010", a); end
    endtask

    task automatic test_random();
        logic [3:0] a;
        for (int i = 0; i < 12; i++) begin
            do_job(4'($urandom_range(1, 15)), 8'($urandom), int'($urandom_range(0, 8)),
                   int'($urandom_range(0, 8)), int'($urandom_range(0, 8)), a);
        end
    endtask

`ifdef CRANE_ARB_FIXED_PRIO_EN
    task automatic test_fixed_prio();
        logic [3:0] a;
        for (int i = 0; i < 3; i++) begin
            do_job(4'b1010, 8'($urandom), 1, 1, 1, a);
            tests++;
            if (a !== 4'b0010) begin fails++; $display("FAIL fixed_prio[%0d]: ack=%b want 0010", i, a); end
        end
        do_job(4'b1000, 8'($urandom), 1, 1, 1, a);
        tests++;
        if (a !== 4'b1000) begin fails++; $display("FAIL fixed_low: ack=%b want 1000", a); end
    endtask
`endif

    initial begin
        bus.req          = 4'b0;
        bus.req_angle    = 8'h00;
        bus.crane_action = c_nothing;
        bus.fault_clr    = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_job();
        test_round_robin();
        test_watchdog();
        test_mid_reset();
        test_random();
`ifdef CRANE_ARB_FIXED_PRIO_EN
        test_fixed_prio();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/crane_job_arbiter.md
# crane_job_arbiter

Shares a single crane controller between four loading stations. Each station posts a pick request with a target boom angle. The arbiter grants one request at a time and launches the crane's job with a one-cycle `write_mode` pulse and a held `mode_in` angle. It tracks the job through the crane's `action` output until the crane is back at rest, then releases the crane to the next station. It sits between the station request logic and the crane FSM, and includes a watchdog that latches a fault if the crane stalls.

## Interface
- `N_REQ`, 4: number of requesters (fixed at 4 in this revision).
- `TIMEOUT`, 8'd200: maximum cycles allowed in any one job-tracking state.
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset_n`  in  1  reset; one clock; reset is synchronous and active-low.
- `req`  in  4  per-station request level; held until `ack`.
- `req_angle`  in  8  2-bit target angle per station; station i uses bits [2i+1:2i].
- `crane_action`  in  3  crane action code (dn=000, A1=001, up=010, A2=011, r1=100, r2=101, nothing=110).
- `fault_clr`  in  1  clears the watchdog fault.
- `ack`  out  4  one-hot; one-cycle pulse when a request is granted.
- `done`  out  4  one-hot; one-cycle pulse when the granted job completes.
- `crane_write_mode`  out  1  one-cycle job-start pulse to the crane.
- `crane_mode_in`  out  2  target angle; held for the whole job.
- `busy`  out  1  high whenever the state is not IDLE.
- `fault`  out  1  watchdog fault flag; sticky until cleared.

## Operation
- States: IDLE, ISSUE, WAIT_START, RUN, RETURN, FAULT.
- **IDLE**
  - If `req` is non-zero, pick a winner and latch its index and angle.
  - Register `ack`=onehot(winner), `crane_write_mode`=1, `crane_mode_in`=angle.
  - Go to ISSUE.
- **ISSUE**
  - Deassert `ack` and `crane_write_mode`. Go to WAIT_START.
- **WAIT_START**
  - Wait for `crane_action`==dn, meaning rotation is done and lowering has begun. Then go to RUN.
- **RUN**
  - Wait for `crane_action`==r2. Then go to RETURN.
- **RETURN**
  - Wait for `crane_action`==nothing, meaning the crane is back at angle 0 and idle.
  - Then pulse `done`=onehot(winner), set the pointer to (winner+1) mod 4, and go to IDLE.
- **Arbitration**
  - Round-robin: search `req` starting at the pointer index, wrapping from 3 to 0.
  - The pointer resets to 0.
- **Watchdog**
  - An 8-bit counter runs in WAIT_START, RUN and RETURN, and clears on every state change.
  - When the counter reaches TIMEOUT-1, go to FAULT and set `fault`=1.
- **FAULT**
  - Hold `crane_write_mode`=0 and ignore `req`.
  - When `fault_clr`=1: clear `fault`, set the pointer to winner+1, go to IDLE. No `done` pulse is issued.
- **Request handling**
  - `req` changes after the grant are ignored until the next IDLE.
  - The requester must drop its `req` upon `ack`. A `req` still held in IDLE is treated as a new job.
- **Angle 0** is a legal target; the crane starts lowering immediately and WAIT_START still waits for dn.

## Timing
- Reset values (reset_n=0 at a rising edge):
  - state=IDLE, `ack`=0, `done`=0, `crane_write_mode`=0, `crane_mode_in`=0, `busy`=0, `fault`=0, pointer=0, watchdog counter=0.
- Reset mid-job aborts the job; the crane is reset separately by system logic.
- All outputs are registered.
- `ack` and `crane_write_mode` are high in the same single cycle, 1 cycle after `req` is sampled in IDLE.
- `done` is high for exactly one cycle, beginning 1 cycle after `crane_action`==nothing is sampled in RETURN.
- `busy` falls together with `done`.
- Minimum gap between consecutive grants is one IDLE cycle. A `req` present during the `done` cycle is granted at the next edge.
- If `fault_clr` arrives on the same edge the fault is raised, it is ignored; it must be seen while in FAULT.

## Configuration
- `CRANE_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority, `req[0]` highest and `req[3]` lowest; the pointer is unused and held at 0.
  - Undefined: round-robin as described above.

## Structure
- Shared package `crane_pkg` holds:
  - the action code constants (dn..nothing), shared with the crane FSM;
  - the arbiter state encoding;
  - the `N_REQ` constant.
- One sub-module, `crane_rr_pick`: combinational 4-way pick from a request vector and pointer, returning a one-hot grant and a valid flag.

## Test plan
- **Reset:** hold reset_n=0 for 2 cycles with `req`=4'b1111 → all outputs 0, `crane_mode_in`=0, no `ack`.
- **Single job:**
  - Stimulus: `req`=4'b0100 with angle2=3; crane model drives action nothing → dn → up → r2 → nothing.
  - Response: `ack`=0100 and `crane_write_mode`=1 in the same cycle; `crane_mode_in`=3 until IDLE; `done`=0100 for one cycle; then `busy`=0.
- **Round-robin:** `req`=4'b1011 held, pointer 0 → grants in order 0, 1, 3, 0, each only after the previous `done`.
- **Watchdog:**
  - Stimulus: TIMEOUT=16; action stays nothing after the grant.
  - Response: `fault`=1 after 16 cycles in WAIT_START.
  - Then: `fault_clr` pulse → IDLE, no `done`, pointer advanced.
- **Mid-job reset:** reset_n=0 during RUN → next edge `busy`=0, `crane_write_mode`=0; a following `req`=0010 is granted `ack`=0010.
- **Fixed priority** (macro defined): `req`=4'b1010 repeated → `req[1]` granted every time; `req[3]` granted only when `req[1]`=0.
